// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit per cycle, LSB first,
// WIDTH-cycle RUN phase followed by a one-cycle DONE result pulse.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_borrow_out;
  logic [CW-1:0]    r_cnt;
  logic             w_d;
  logic             w_bout;
  logic             w_accept;
  logic             w_last;

  full_subtractor u_fs (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_bout)
  );

  // A new request is taken from IDLE or DONE; start during RUN is ignored.
  assign w_accept = (r_state != RUN) && start;
  assign w_last   = (r_state == RUN) && (r_cnt == '0);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    // NOTE: default assigned first so no path leaves w_next unassigned (no latch).
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (r_cnt == '0) w_next = DONE;
      DONE:    w_next = start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a          <= '0;
      r_b          <= '0;
      r_work       <= '0;
      r_diff       <= '0;
      r_borrow     <= 1'b0;
      r_borrow_out <= 1'b0;
      r_cnt        <= '0;
    end else if (w_accept) begin
      r_a      <= a;
      r_b      <= b;
      r_borrow <= 1'b0;
      r_cnt    <= CW'(WIDTH - 1);
    end else if (r_state == RUN) begin
      r_a      <= r_a >> 1;
      r_b      <= r_b >> 1;
      r_work   <= {w_d, r_work[WIDTH-1:1]};
      r_borrow <= w_bout;
      if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
      // Publish the result with the final bit folded in, on entry to DONE.
      if (w_last) begin
        r_diff       <= {w_d, r_work[WIDTH-1:1]};
        r_borrow_out <= w_bout;
      end
    end
  end

  assign busy       = (r_state == RUN);
  assign done       = (r_state == DONE);
  assign diff       = r_diff;
  assign borrow_out = r_borrow_out;

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits; legal range 2..16.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high; one clock, synchronous active-high reset.
REQ-004 start  input  1  request to begin a subtraction; sampled each rising edge.
REQ-005 a  input  WIDTH  minuend; sampled only in the cycle start is accepted.
REQ-006 b  input  WIDTH  subtrahend; sampled only in the cycle start is accepted.
REQ-007 busy  output  1  high while an operation is in progress.
REQ-008 done  output  1  single-cycle pulse when diff and borrow_out are updated.
REQ-009 diff  output  WIDTH  result a - b, modulo 2^WIDTH.
REQ-010 borrow_out  output  1  final borrow; 1 when a < b, unsigned.

Function
REQ-011 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-012 IDLE: start=1 SHALL latch a and b into shift registers, clear the borrow flop, load the bit counter with WIDTH-1 and move to RUN.
REQ-013 RUN SHALL process one bit per cycle, LSB first.
REQ-014 RUN bit step SHALL compute d = a0 ^ b0 ^ br and br' = (~a0 & b0) | (~(a0 ^ b0) & br).
REQ-015 RUN shift step SHALL shift both operand registers right by one and shift d into the MSB of the working-difference register.
REQ-016 RUN SHALL move to DONE after the bit processed with counter = 0; the counter SHALL NOT wrap.
REQ-017 On entry to DONE, the working difference SHALL be copied to diff and the final borrow to borrow_out.
REQ-018 done SHALL be 1 for exactly the one cycle the FSM is in DONE.
REQ-019 Latency: start accepted at edge N gives done=1 in the cycle after edge N+WIDTH, i.e. WIDTH+1 cycles after acceptance.
REQ-020 busy SHALL be 1 in RUN and 0 in IDLE and DONE.
REQ-021 diff and borrow_out SHALL hold their previous values throughout RUN and change only on entry to DONE.
REQ-022 From DONE, start=1 SHALL be accepted exactly as in IDLE (back-to-back operation, no idle gap).
REQ-023 From DONE, start=0 SHALL return the FSM to IDLE.
REQ-024 start while busy=1 SHALL be ignored, with no effect on operands, counter or outputs.
REQ-025 Changes on a or b after acceptance SHALL NOT affect the result in progress.

Reset
REQ-026 rst=1 at any rising edge SHALL force IDLE and clear the operand registers, working difference, borrow flop and counter.
REQ-027 rst=1 SHALL set busy=0, done=0, diff=0 and borrow_out=0, with priority over start.
REQ-028 Reset mid-RUN SHALL abandon the operation with no done pulse and no output update.
REQ-029 The first edge with rst=0 SHALL sample start normally.

Structure
REQ-030 Package serial_sub_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the WIDTH default constant.
REQ-031 The counter width, $clog2(WIDTH), SHALL be derived locally from WIDTH.
REQ-032 A combinational 1-bit sub-module, full_subtractor (inputs a, b, bin; outputs d, bout), SHALL implement REQ-014.
REQ-033 The Tiny Tapeout top-level wrapper is out of scope for this block.

Verification
REQ-034 a=0x05, b=0x03, start pulse, WIDTH=8 -> done pulse in the 9th cycle after acceptance; diff=0x02, borrow_out=0; busy high for 8 cycles.
REQ-035 a=0x03, b=0x05 -> diff=0xFE, borrow_out=1; also a=0x00, b=0x00 -> diff=0x00, borrow_out=0; also a=0xFF, b=0x01 -> diff=0xFE, borrow_out=0.
REQ-036 Start with a=0x10, b=0x01; assert start again with a=0xAA, b=0x55 during RUN -> single result diff=0x0F, borrow_out=0; exactly one done pulse.
REQ-037 Start held high continuously with a=0x80, b=0x7F -> results repeat every 9 cycles (diff=0x01, borrow_out=0); done pulses back-to-back with no IDLE cycle between operations.
REQ-038 Complete a=0x05, b=0x03 (diff=0x02), start a=0x01, b=0x02, assert rst at cycle 4 -> next cycle busy=0, diff=0x00, borrow_out=0; no done pulse follows.
REQ-039 Randomized sweep of a and b, 1000 operations, WIDTH=8 and WIDTH=16 -> diff == (a-b) mod 2^WIDTH and borrow_out == (a<b) on every done.
